// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: host-transmit FSM states, frame size,
// default line timings and common keyboard command bytes.
package ps2_pkg;

  typedef enum logic [2:0] {
    IDLE,
    INHIBIT,
    RTS,
    SHIFT,
    ACK,
    WAIT_IDLE
  } ps2_tx_state_t;

  localparam int PS2_FRAME_BITS         = 11;
  localparam int PS2_DEF_INHIBIT_CYCLES = 5000;
  localparam int PS2_DEF_TIMEOUT_CYCLES = 750000;

  localparam logic [7:0] CMD_SET_LEDS = 8'hED;
  localparam logic [7:0] CMD_RESET    = 8'hFF;
  localparam logic [7:0] CMD_ENABLE   = 8'hF4;
  localparam logic [7:0] RESP_ACK     = 8'hFA;

  function automatic logic ps2_odd_parity(input logic [7:0] b);
    return ~^b;
  endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// Two-flop synchronizer for PS2_Clock/PS2_Data plus a clock falling-edge flag.
// Edge flag appears 2 cycles after the pin change; no backpressure.
module ps2_line_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clk_pin,
  input  logic i_dat_pin,
  output logic o_clk_sync,
  output logic o_dat_sync,
  output logic o_clk_fall
);

  logic [1:0] r_clk_sync;
  logic [1:0] r_dat_sync;
  logic       r_clk_prev;

  // Reset to the released (high) bus level so no false edge follows reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_clk_sync <= 2'b11;
      r_dat_sync <= 2'b11;
      r_clk_prev <= 1'b1;
    end else begin
      r_clk_sync <= {r_clk_sync[0], i_clk_pin};
      r_dat_sync <= {r_dat_sync[0], i_dat_pin};
      r_clk_prev <= r_clk_sync[1];
    end
  end

  assign o_clk_sync = r_clk_sync[1];
  assign o_dat_sync = r_dat_sync[1];
  assign o_clk_fall = r_clk_prev & ~r_clk_sync[1];

endmodule

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 byte transmitter (inhibit, RTS, shift, ACK) with open-drain enables.
// Data follows a device clock fall by 3 cycles; tx_ready is high only in IDLE, requests while busy are dropped.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int INHIBIT_CYCLES = PS2_DEF_INHIBIT_CYCLES,
  parameter int TIMEOUT_CYCLES = PS2_DEF_TIMEOUT_CYCLES
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       busy,
  output logic       tx_done,
  output logic       tx_err,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe
);

  localparam int IW = $clog2(INHIBIT_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [IW-1:0] INH_LAST  = IW'(INHIBIT_CYCLES - 1);
  localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [3:0]    LAST_EDGE = 4'(PS2_FRAME_BITS - 2);

  ps2_tx_state_t r_state;
  logic [IW-1:0] r_inh_cnt;
  logic [TW-1:0] r_to_cnt;
  logic [3:0]    r_edge_cnt;
  logic [8:0]    r_shift;
  logic          r_ready, r_busy, r_done, r_err, r_clk_oe, r_data_oe;
  logic          w_clk_sync, w_dat_sync, w_clk_fall, w_timeout;

  ps2_line_sync u_sync (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_clk_pin  (ps2_clk_in),
    .i_dat_pin  (ps2_data_in),
    .o_clk_sync (w_clk_sync),
    .o_dat_sync (w_dat_sync),
    .o_clk_fall (w_clk_fall)
  );

  // A falling edge in the same cycle as the limit still counts as activity.
  assign w_timeout = (r_to_cnt == TO_LAST) && !w_clk_fall;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_inh_cnt  <= '0;
      r_to_cnt   <= '0;
      r_edge_cnt <= '0;
      r_shift    <= '0;
      r_ready    <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
      r_clk_oe   <= 1'b0;
      r_data_oe  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      case (r_state)
        IDLE: begin
          r_ready <= 1'b1;
          if (tx_valid && r_ready) begin
            r_shift   <= {ps2_odd_parity(tx_data), tx_data};
            r_inh_cnt <= '0;
            r_clk_oe  <= 1'b1;
            r_busy    <= 1'b1;
            r_ready   <= 1'b0;
            r_state   <= INHIBIT;
          end
        end
        INHIBIT: begin
          if (r_inh_cnt == INH_LAST) begin
            r_data_oe <= 1'b1;
            r_state   <= RTS;
          end else begin
            r_inh_cnt <= r_inh_cnt + IW'(1);
          end
        end
        RTS: begin
          r_clk_oe   <= 1'b0;
          r_edge_cnt <= '0;
          r_to_cnt   <= '0;
          r_state    <= SHIFT;
        end
        SHIFT, ACK, WAIT_IDLE: begin
          r_to_cnt <= w_clk_fall ? '0 : r_to_cnt + TW'(1);
          if (w_timeout) begin
            r_err     <= 1'b1;
            r_busy    <= 1'b0;
            r_clk_oe  <= 1'b0;
            r_data_oe <= 1'b0;
            r_state   <= IDLE;
          end else if (r_state == SHIFT) begin
            if (w_clk_fall) begin
              r_edge_cnt <= r_edge_cnt + 4'(1);
              if (r_edge_cnt == LAST_EDGE) begin
                r_data_oe <= 1'b0;
                r_state   <= ACK;
              end else begin
                r_data_oe <= ~r_shift[0];
                r_shift   <= {1'b0, r_shift[8:1]};
              end
            end
          end else if (r_state == ACK) begin
            if (w_clk_fall) begin
              if (!w_dat_sync) begin
                r_state <= WAIT_IDLE;
              end else begin
                r_err   <= 1'b1;
                r_busy  <= 1'b0;
                r_state <= IDLE;
              end
            end
          end else if (w_clk_sync && w_dat_sync) begin
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign tx_ready    = r_ready;
  assign busy        = r_busy;
  assign tx_done     = r_done;
  assign tx_err      = r_err;
  assign ps2_clk_oe  = r_clk_oe;
  assign ps2_data_oe = r_data_oe;

endmodule
